// File: rtl/vending_fsm_param.sv
// Coin-credit vending controller: nickel/dime/quarter credit against PRICE, vend and change via valid/ready.
// Latency: price-reaching coin -> io_valid the next cycle; io_reject is combinational from the coin inputs.
// Backpressure: io_valid/io_change_valid hold until io_ready/io_change_ready; coins offered meanwhile are rejected.
// Optional: define VENDING_TIMEOUT_EN for an inactivity auto-refund after TIMEOUT_CYCLES idle COLLECT cycles.
module vending_fsm_param #(
  parameter int PRICE          = 4,
  parameter int CREDIT_W       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_nickel,
  input  logic                io_dime,
  input  logic                io_quarter,
  input  logic                io_cancel,
  input  logic                io_ready,
  input  logic                io_change_ready,
  output logic                io_valid,
  output logic                io_change_valid,
  output logic [CREDIT_W-1:0] io_change,
  output logic                io_credit_unused_guard,
  output logic [CREDIT_W-1:0] io_credit,
  output logic                io_reject
);

  localparam int SW = CREDIT_W + 1;

  // Elaboration-time parameter sanity
  if (PRICE < 1 || PRICE > (1 << CREDIT_W) - 1) begin : g_bad_price
    $error("PRICE out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {COLLECT = 2'd0, VEND = 2'd1, REFUND = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic [SW-1:0]       coin_sum;
  logic [SW-1:0]       credit_sum;
  logic [SW-1:0]       change_full;
  logic                coin_any;
  logic                overflow;
  logic                coin_ok;
  logic                reach;
  logic                refund_now;
  logic                timeout_hit;

  // Coin arithmetic; credit never exceeds 2^CREDIT_W-1 so the sum cannot wrap SW bits
  always_comb begin
    coin_sum    = SW'(io_nickel) + SW'({io_dime, 1'b0}) + SW'({io_quarter, 1'b0, io_quarter});
    credit_sum  = {1'b0, credit_q} + coin_sum;
    change_full = credit_sum - SW'(PRICE);
    coin_any    = (coin_sum != '0);
    overflow    = credit_sum[CREDIT_W];
    coin_ok     = coin_any && !overflow;
    reach       = (credit_sum >= SW'(PRICE));
    refund_now  = (state_q == COLLECT) && (io_cancel || timeout_hit) && (credit_q != '0);
  end

`ifdef VENDING_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;

  // Idle counter: runs only while holding credit with no coin accepted; fires as it reaches TIMEOUT_CYCLES
  always_comb begin
    idle_d      = '0;
    timeout_hit = 1'b0;
    if (state_q == COLLECT && credit_q != '0 && !coin_ok) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
      else                                   idle_d      = idle_q + 1'b1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State, credit and change registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      change_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
    end
  end

  // Next-state: cancel/timeout beats overflow beats vend beats accumulate
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    case (state_q)
      COLLECT: begin
        if (refund_now) begin
          change_d = credit_q;
          credit_d = '0;
          state_d  = REFUND;
        end else if (coin_ok) begin
          if (reach) begin
            change_d = change_full[CREDIT_W-1:0];
            credit_d = '0;
            state_d  = VEND;
          end else begin
            credit_d = credit_sum[CREDIT_W-1:0];
          end
        end
      end
      VEND: begin
        if (io_ready) state_d = (change_q != '0) ? REFUND : COLLECT;
      end
      REFUND: begin
        if (io_change_ready) begin
          change_d = '0;
          state_d  = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Outputs; reject is masked while reset is held so everything reads 0 immediately
  always_comb begin
    io_valid               = (state_q == VEND);
    io_change_valid        = (state_q == REFUND);
    io_change              = (state_q == REFUND) ? change_q : '0;
    io_credit              = credit_q;
    io_credit_unused_guard = 1'b0;
    io_reject              = reset && coin_any &&
                             ((state_q != COLLECT) || refund_now || overflow);
  end

endmodule

// File: tb/tb_vending_fsm_param.sv
module tb_vending_fsm_param;

  logic clk = 1'b0;
  logic reset;
  logic n, d, q, c, rdy, crdy;

  logic       v4, cv4, rj4, g4;
  logic [3:0] chg4, cr4;
  logic       v15, cv15, rj15, g15;
  logic [3:0] chg15, cr15;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vending_fsm_param dut (
    .clk(clk), .reset(reset),
    .io_nickel(n), .io_dime(d), .io_quarter(q), .io_cancel(c),
    .io_ready(rdy), .io_change_ready(crdy),
    .io_valid(v4), .io_change_valid(cv4), .io_change(chg4),
    .io_credit_unused_guard(g4), .io_credit(cr4), .io_reject(rj4)
  );

  vending_fsm_param #(.PRICE(15), .CREDIT_W(4)) dut15 (
    .clk(clk), .reset(reset),
    .io_nickel(n), .io_dime(d), .io_quarter(q), .io_cancel(c),
    .io_ready(rdy), .io_change_ready(crdy),
    .io_valid(v15), .io_change_valid(cv15), .io_change(chg15),
    .io_credit_unused_guard(g15), .io_credit(cr15), .io_reject(rj15)
  );

  typedef struct {
    logic [5:0] in;   // {nickel, dime, quarter, cancel, ready, change_ready}
    logic       rj;   // io_reject before the edge
    logic       v;    // io_valid after the edge
    logic       cv;   // io_change_valid after the edge
    logic [3:0] chg;  // io_change after the edge
    logic [3:0] cr;   // io_credit after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {n, d, q, c, rdy, crdy} = in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [5:0] in, input logic rj, input logic v, input logic cv,
                     input logic [3:0] chg, input logic [3:0] cr);
    vec_t e;
    e.in = in; e.rj = rj; e.v = v; e.cv = cv; e.chg = chg; e.cr = cr;
    vecs.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(6'b000000);
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    drive(6'b000000);
    #2;
    chk("rst_valid", 8'(v4), 8'd0);
    chk("rst_cvalid", 8'(cv4), 8'd0);
    chk("rst_change", 8'(chg4), 8'd0);
    chk("rst_credit", 8'(cr4), 8'd0);
    chk("rst_reject", 8'(rj4), 8'd0);
    tick();
    reset = 1'b1;

    // Default PRICE=4: exact vend, vend with change, busy rejects, cancel paths
    //   in           rj v  cv chg cr
    add(6'b100000, 0, 0, 0, 0, 1);
    add(6'b100000, 0, 0, 0, 0, 2);
    add(6'b100000, 0, 0, 0, 0, 3);
    add(6'b100000, 0, 1, 0, 0, 0);
    add(6'b000000, 0, 1, 0, 0, 0);
    add(6'b000010, 0, 0, 0, 0, 0);
    add(6'b100000, 0, 0, 0, 0, 1);
    add(6'b100000, 0, 0, 0, 0, 2);
    add(6'b100000, 0, 0, 0, 0, 3);
    add(6'b010000, 0, 1, 0, 0, 0);
    add(6'b100000, 1, 1, 0, 0, 0);
    add(6'b000010, 0, 0, 1, 1, 0);
    add(6'b000000, 0, 0, 1, 1, 0);
    add(6'b100000, 1, 0, 1, 1, 0);
    add(6'b000001, 0, 0, 0, 0, 0);
    add(6'b010000, 0, 0, 0, 0, 2);
    add(6'b100000, 0, 0, 0, 0, 3);
    add(6'b100100, 1, 0, 1, 3, 0);
    add(6'b000001, 0, 0, 0, 0, 0);
    add(6'b100100, 0, 0, 0, 0, 1);
    add(6'b001000, 0, 1, 0, 0, 0);
    add(6'b000011, 0, 0, 1, 2, 0);
    add(6'b000001, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      #1;
      chk($sformatf("v%0d_reject", i), 8'(rj4), 8'(vecs[i].rj));
      tick();
      chk($sformatf("v%0d_valid", i), 8'(v4), 8'(vecs[i].v));
      chk($sformatf("v%0d_cvalid", i), 8'(cv4), 8'(vecs[i].cv));
      chk($sformatf("v%0d_change", i), 8'(chg4), 8'(vecs[i].chg));
      chk($sformatf("v%0d_credit", i), 8'(cr4), 8'(vecs[i].cr));
    end

    // Reset held mid-VEND with the dispenser stalled
    do_reset();
    drive(6'b100000);
    repeat (4) tick();
    drive(6'b000000);
    chk("pre_rst_valid", 8'(v4), 8'd1);
    reset = 1'b0;
    drive(6'b100000);
    #1;
    chk("in_rst_valid", 8'(v4), 8'd0);
    chk("in_rst_cvalid", 8'(cv4), 8'd0);
    chk("in_rst_credit", 8'(cr4), 8'd0);
    chk("in_rst_reject", 8'(rj4), 8'd0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_credit3", 8'(cr4), 8'd3);
    chk("post_rst_novend", 8'(v4), 8'd0);
    tick();
    chk("post_rst_vend", 8'(v4), 8'd1);
    drive(6'b000010);
    tick();
    chk("post_rst_done", 8'(v4), 8'd0);

    // PRICE=15: overflow rejection then exact vend
    do_reset();
    drive(6'b001000); tick();
    drive(6'b001000); tick();
    drive(6'b010000); tick();
    chk("p15_credit12", 8'(cr15), 8'd12);
    drive(6'b011000);
    #1;
    chk("p15_ovf_reject", 8'(rj15), 8'd1);
    tick();
    chk("p15_ovf_credit", 8'(cr15), 8'd12);
    drive(6'b110000);
    #1;
    chk("p15_vend_noreject", 8'(rj15), 8'd0);
    tick();
    chk("p15_valid", 8'(v15), 8'd1);
    drive(6'b000010);
    tick();
    chk("p15_after_valid", 8'(v15), 8'd0);
    chk("p15_no_change", 8'(cv15), 8'd0);
    drive(6'b000000);

`ifdef VENDING_TIMEOUT_EN
    // Inactivity refund after 16 idle cycles, restarted by a second coin
    do_reset();
    drive(6'b100000); tick();
    drive(6'b000000);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("to1_idle%0d", k), 8'(cv4), 8'd0);
    end
    tick();
    chk("to1_cvalid", 8'(cv4), 8'd1);
    chk("to1_change", 8'(chg4), 8'd1);
    drive(6'b000001); tick();
    drive(6'b100000); tick();
    drive(6'b000000);
    repeat (9) tick();
    chk("to2_early", 8'(cv4), 8'd0);
    drive(6'b100000); tick();
    drive(6'b000000);
    chk("to2_credit2", 8'(cr4), 8'd2);
    repeat (15) tick();
    chk("to2_not_yet", 8'(cv4), 8'd0);
    tick();
    chk("to2_cvalid", 8'(cv4), 8'd1);
    chk("to2_change", 8'(chg4), 8'd2);
    drive(6'b000001); tick();
    drive(6'b000000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute runaway guard
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
